mem_bank_bridge: RTL and testbench

Host-side access engine between the AXI-Lite register block and a parametrised number of on-chip memory banks (IMEM, DMEM, MRAM0..n) of the RISC-V/matrix-ALU core. It replaces fixed per-memory wiring with one request/response channel, a bank select, configurable read latency and a core-busy interlock. Each request is single-beat. Out-of-range and interlocked requests complete with an error response, and the block counts them.

---
 rtl/mem_bank_bridge.sv | 238 +++++++++++++++++++++++
 tb/tb_mem_bank_bridge.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank_bridge.sv
// rtl/mem_bank_bridge.sv - single-beat host access engine into N on-chip memory banks
//
// Purpose: one request/response channel from the register block to IMEM/DMEM/MRAM
// banks, with bank select, configurable read latency, a core-busy interlock and a
// saturating count of refused requests.
//
// Ports:
//   s00_axi_aclk / s00_axi_aresetn : clock, asynchronous active-low reset
//   i_core_busy                    : core running, host accesses are refused
//   i_req_* / o_req_ready          : request channel (we, bank, addr, wdata, strb)
//   o_rsp_* / i_rsp_ready          : response channel (rdata, err)
//   o_err_cnt                      : saturating refused-request counter
//   o_bank_* / i_bank_q            : flattened per-bank SRAM ports, bank 0 in the LSBs
//
// Optional feature macro: MEM_BRIDGE_STRB_EN (byte-strobed read-modify-write).

module mem_bank_bridge #(
  parameter int NUM_BANKS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int RD_LAT     = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic                            i_core_busy,
  input  logic                            i_req_valid,
  output logic                            o_req_ready,
  input  logic                            i_req_we,
  input  logic [3:0]                      i_req_bank,
  input  logic [ADDR_WIDTH-1:0]           i_req_addr,
  input  logic [DATA_WIDTH-1:0]           i_req_wdata,
  input  logic [DATA_WIDTH/8-1:0]         i_req_strb,
  output logic                            o_rsp_valid,
  input  logic                            i_rsp_ready,
  output logic [DATA_WIDTH-1:0]           o_rsp_rdata,
  output logic                            o_rsp_err,
  output logic [CNT_WIDTH-1:0]            o_err_cnt,
  output logic [NUM_BANKS*ADDR_WIDTH-1:0] o_bank_addr,
  output logic [NUM_BANKS-1:0]            o_bank_ce,
  output logic [NUM_BANKS-1:0]            o_bank_we,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] o_bank_d,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] i_bank_q
);

  localparam int                  STRB_W     = DATA_WIDTH / 8;
  localparam logic [4:0]          BANK_LIMIT = 5'(NUM_BANKS);
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [1:0]          LAT_INIT   = 2'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_RDMOD,
    S_MERGE
  } state_t;

  state_t state, state_d;

  // Holds o_req_ready low until the first edge after reset release.
  logic                  armed_q;

  logic                  we_q;
  logic [3:0]            bank_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [CNT_WIDTH-1:0]  err_cnt_q;
  logic [1:0]            cnt_q;

  logic                  accept;
  logic                  issue;
  logic                  issue_we;
  logic                  req_bad;
  logic [DATA_WIDTH-1:0] q_sel;

`ifdef MEM_BRIDGE_STRB_EN
  logic [STRB_W-1:0]     strb_q;
  logic [DATA_WIDTH-1:0] rd_word_q;
  logic [DATA_WIDTH-1:0] merged;
`else
  logic                  strb_unused;
  assign strb_unused = ^i_req_strb;
`endif

  assign req_bad = i_core_busy
                 | ({1'b0, i_req_bank} >= BANK_LIMIT)
                 | ({1'b0, i_req_addr} >= ADDR_LIMIT);

  // Read-data mux; bank_q is range-checked at accept so it always hits a bank.
  always_comb begin
    q_sel = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_q == 4'(b)) q_sel = i_bank_q[b*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef MEM_BRIDGE_STRB_EN
  always_comb begin
    merged = rd_word_q;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb_q[i]) merged[i*8 +: 8] = wdata_q[i*8 +: 8];
    end
  end
`endif

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state   <= S_IDLE;
      armed_q <= 1'b0;
    end else begin
      state   <= state_d;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    accept      = 1'b0;
    issue       = 1'b0;
    issue_we    = 1'b0;
    case (state)
      S_IDLE: begin
        o_req_ready = armed_q;
        if (armed_q && i_req_valid) begin
          accept = 1'b1;
          if (req_bad) begin
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
`ifdef MEM_BRIDGE_STRB_EN
            // Zero strobe is a no-op write; a partial strobe needs the old word first.
            if (i_req_we && (i_req_strb == '0))      state_d = S_RESP;
            else if (i_req_we && (i_req_strb != '1)) state_d = S_RDMOD;
`endif
          end
        end
      end
      S_ISSUE: begin
        issue    = 1'b1;
        issue_we = we_q;
        state_d  = we_q ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        // we_q is only set in WAIT during a read-modify-write.
        if (cnt_q == 2'd0) state_d = we_q ? S_MERGE : S_RESP;
      end
      S_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) state_d = S_IDLE;
      end
`ifdef MEM_BRIDGE_STRB_EN
      S_RDMOD: begin
        issue    = 1'b1;
        issue_we = 1'b0;
        state_d  = S_WAIT;
      end
      S_MERGE: begin
        state_d = S_ISSUE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      we_q      <= 1'b0;
      bank_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      cnt_q     <= '0;
`ifdef MEM_BRIDGE_STRB_EN
      strb_q    <= '0;
      rd_word_q <= '0;
`endif
    end else begin
      if (accept) begin
        we_q    <= i_req_we;
        bank_q  <= i_req_bank;
        addr_q  <= i_req_addr;
        wdata_q <= i_req_wdata;
        rdata_q <= '0;
        err_q   <= req_bad;
`ifdef MEM_BRIDGE_STRB_EN
        strb_q  <= i_req_strb;
`endif
        if (req_bad && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
      end
      if (issue && !issue_we) cnt_q <= LAT_INIT;
      if (state == S_WAIT) begin
        if (cnt_q != 2'd0) begin
          cnt_q <= cnt_q - 2'd1;
        end else if (!we_q) begin
          rdata_q <= q_sel;
        end
`ifdef MEM_BRIDGE_STRB_EN
        else begin
          rd_word_q <= q_sel;
        end
`endif
      end
`ifdef MEM_BRIDGE_STRB_EN
      if (state == S_MERGE) wdata_q <= merged;
`endif
    end
  end

  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;
  assign o_err_cnt   = err_cnt_q;

  // Bank strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    o_bank_ce   = '0;
    o_bank_we   = '0;
    o_bank_addr = '0;
    o_bank_d    = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (issue && (bank_q == 4'(b))) begin
        o_bank_ce[b]                            = 1'b1;
        o_bank_we[b]                            = issue_we;
        o_bank_addr[b*ADDR_WIDTH +: ADDR_WIDTH] = addr_q;
        o_bank_d[b*DATA_WIDTH +: DATA_WIDTH]    = wdata_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_bank_bridge.sv
// tb/tb_mem_bank_bridge.sv - directed self-checking bench for mem_bank_bridge

module tb_mem_bank_bridge;

  localparam int NB    = 4;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 1024;
  localparam int LAT   = 1;
  localparam int CW    = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             busy = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_we = 1'b0;
  logic [3:0]       req_bank = '0;
  logic [AW-1:0]    req_addr = '0;
  logic [DW-1:0]    req_wdata = '0;
  logic [DW/8-1:0]  req_strb = '1;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;
  logic [CW-1:0]    err_cnt;
  logic [NB*AW-1:0] bank_addr;
  logic [NB-1:0]    bank_ce;
  logic [NB-1:0]    bank_we;
  logic [NB*DW-1:0] bank_d;
  logic [NB*DW-1:0] bank_q = '0;

  always #5 clk = ~clk;

  mem_bank_bridge #(
    .NUM_BANKS (NB),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .MEM_DEPTH (DEPTH),
    .RD_LAT    (LAT),
    .CNT_WIDTH (CW)
  ) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_aresetn(rst_n),
    .i_core_busy    (busy),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_we       (req_we),
    .i_req_bank     (req_bank),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .i_req_strb     (req_strb),
    .o_rsp_valid    (rsp_valid),
    .i_rsp_ready    (rsp_ready),
    .o_rsp_rdata    (rsp_rdata),
    .o_rsp_err      (rsp_err),
    .o_err_cnt      (err_cnt),
    .o_bank_addr    (bank_addr),
    .o_bank_ce      (bank_ce),
    .o_bank_we      (bank_we),
    .o_bank_d       (bank_d),
    .i_bank_q       (bank_q)
  );

  // Bank model: synchronous SRAM with one cycle read latency.
  logic [DW-1:0] mem [NB][DEPTH];
  logic          mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int b = 0; b < NB; b++)
        for (int a = 0; a < DEPTH; a++) mem[b][a] <= '0;
      mem_init <= 1'b1;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (bank_ce[b]) begin
          if (bank_we[b]) mem[b][bank_addr[b*AW +: 10]] <= bank_d[b*DW +: DW];
          else            bank_q[b*DW +: DW] <= mem[b][bank_addr[b*AW +: 10]];
        end
      end
    end
  end

  // Bank-port monitor.
  int               ce_count = 0;
  int               multi_ce = 0;
  logic [NB-1:0]    cap_ce = '0;
  logic [NB-1:0]    cap_we = '0;
  logic [NB*AW-1:0] cap_addr = '0;
  logic [NB*DW-1:0] cap_d = '0;

  always @(posedge clk) begin
    if (|bank_ce) begin
      ce_count++;
      cap_ce   = bank_ce;
      cap_we   = bank_we;
      cap_addr = bank_addr;
      cap_d    = bank_d;
    end
    if (!$onehot0(bank_ce)) multi_ce++;
  end

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int lat;
  int ce_base;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one request, waits for the response (bounded), leaves it pending.
  task automatic send(input logic we, input logic [3:0] bank, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] strb, input int busy_rise);
    req_valid = 1'b1;
    req_we    = we;
    req_bank  = bank;
    req_addr  = addr;
    req_wdata = wd;
    req_strb  = strb;
    check("req_ready_idle", req_ready, 1'b1);
    ce_base = ce_count;
    step();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      if (lat == busy_rise) busy = 1'b1;
      step();
      lat++;
    end
    check("rsp_valid_seen", rsp_valid, 1'b1);
  endtask

  task automatic expect_rsp(input string tag, input int elat, input logic eerr,
                            input logic [31:0] erd, input int ece);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_err"}, rsp_err, eerr);
    check({tag, "_rdata"}, rsp_rdata, erd);
    check({tag, "_ce_cycles"}, ce_count - ce_base, ece);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    step();
    step();
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_err_cnt", err_cnt, 8'h0);
    check("rst_bank_ce", bank_ce, 4'h0);
    check("rst_bank_we", bank_we, 4'h0);
    check("rst_bank_addr", bank_addr, 128'h0);
    check("rst_bank_d", bank_d, 128'h0);
    rst_n = 1'b1;
    check("release_ready_low", req_ready, 1'b0);
    step();
    check("release_ready_high", req_ready, 1'b1);

    // Write bank 2 addr 5, then read it back
    send(1'b1, 4'd2, 32'd5, 32'hDEADBEEF, 4'hF, -1);
    expect_rsp("wr_b2", 2, 1'b0, 32'h0, 1);
    check("wr_b2_ce", cap_ce, 4'b0100);
    check("wr_b2_we", cap_we, 4'b0100);
    check("wr_b2_addr", cap_addr, {32'h0, 32'd5, 64'h0});
    check("wr_b2_d", cap_d, {32'h0, 32'hDEADBEEF, 64'h0});
    check("rsp_ready_low_in_resp", req_ready, 1'b0);
    finish_rsp();
    send(1'b0, 4'd2, 32'd5, 32'h0, 4'hF, -1);
    expect_rsp("rd_b2", 2 + LAT, 1'b0, 32'hDEADBEEF, 1);
    check("rd_b2_ce", cap_ce, 4'b0100);
    check("rd_b2_we", cap_we, 4'b0000);
    finish_rsp();

    // Edge-of-range legal accesses
    send(1'b1, 4'd0, 32'd1023, 32'h12345678, 4'hF, -1);
    expect_rsp("wr_b0_top", 2, 1'b0, 32'h0, 1);
    finish_rsp();
    send(1'b1, 4'd3, 32'd0, 32'hCAFEF00D, 4'hF, -1);
    expect_rsp("wr_b3_zero", 2, 1'b0, 32'h0, 1);
    finish_rsp();
    send(1'b0, 4'd0, 32'd1023, 32'h0, 4'hF, -1);
    expect_rsp("rd_b0_top", 2 + LAT, 1'b0, 32'h12345678, 1);
    finish_rsp();

    // Refused requests
    send(1'b0, 4'd4, 32'd0, 32'h0, 4'hF, -1);
    expect_rsp("err_bank", 1, 1'b1, 32'h0, 0);
    check("err_bank_cnt", err_cnt, 8'd1);
    finish_rsp();
    send(1'b1, 4'd1, 32'd1024, 32'h5555AAAA, 4'hF, -1);
    expect_rsp("err_addr", 1, 1'b1, 32'h0, 0);
    check("err_addr_cnt", err_cnt, 8'd2);
    finish_rsp();
    busy = 1'b1;
    send(1'b0, 4'd2, 32'd5, 32'h0, 4'hF, -1);
    expect_rsp("err_busy", 1, 1'b1, 32'h0, 0);
    check("err_busy_cnt", err_cnt, 8'd3);
    finish_rsp();
    busy = 1'b0;

    // Busy rising during WAIT does not abort the read
    send(1'b0, 4'd3, 32'd0, 32'h0, 4'hF, 2);
    expect_rsp("busy_mid", 2 + LAT, 1'b0, 32'hCAFEF00D, 1);
    check("busy_mid_cnt", err_cnt, 8'd3);
    finish_rsp();
    busy = 1'b0;

    // Response backpressure: held response, no new accept
    rsp_ready = 1'b0;
    send(1'b0, 4'd2, 32'd5, 32'h0, 4'hF, -1);
    expect_rsp("hold_rd", 2 + LAT, 1'b0, 32'hDEADBEEF, 1);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_bank  = 4'd1;
    req_addr  = 32'd7;
    req_wdata = 32'h00000055;
    ce_base   = ce_count;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_rdata", rsp_rdata, 32'hDEADBEEF);
      check("hold_req_ready", req_ready, 1'b0);
    end
    check("hold_no_ce", ce_count - ce_base, 0);
    req_valid = 1'b0;
    finish_rsp();
    send(1'b0, 4'd1, 32'd7, 32'h0, 4'hF, -1);
    expect_rsp("hold_not_taken", 2 + LAT, 1'b0, 32'h0, 1);
    finish_rsp();

    // Reset in the middle of a transaction
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_bank  = 4'd2;
    req_addr  = 32'd5;
    step();
    req_valid = 1'b0;
    check("mid_ce_issue", bank_ce, 4'b0100);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ce", bank_ce, 4'h0);
    check("mid_rst_addr", bank_addr, 128'h0);
    check("mid_rst_valid", rsp_valid, 1'b0);
    check("mid_rst_ready", req_ready, 1'b0);
    check("mid_rst_cnt", err_cnt, 8'h0);
    step();
    rst_n = 1'b1;
    step();
    send(1'b0, 4'd2, 32'd5, 32'h0, 4'hF, -1);
    expect_rsp("post_rst_rd", 2 + LAT, 1'b0, 32'hDEADBEEF, 1);
    finish_rsp();

    // Error counter saturation
    for (int i = 0; i < 254; i++) begin
      send(1'b0, 4'd4, 32'd0, 32'h0, 4'hF, -1);
      finish_rsp();
    end
    check("sat_254", err_cnt, 8'hFE);
    send(1'b0, 4'd4, 32'd0, 32'h0, 4'hF, -1);
    finish_rsp();
    check("sat_255", err_cnt, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      send(1'b0, 4'd7, 32'd0, 32'h0, 4'hF, -1);
      finish_rsp();
    end
    check("sat_stick", err_cnt, 8'hFF);

    // Byte strobes
    send(1'b1, 4'd1, 32'd9, 32'h11223344, 4'hF, -1);
    expect_rsp("strb_full", 2, 1'b0, 32'h0, 1);
    finish_rsp();
    send(1'b1, 4'd1, 32'd9, 32'hAABBCCDD, 4'b0101, -1);
`ifdef MEM_BRIDGE_STRB_EN
    expect_rsp("strb_part", 4 + LAT, 1'b0, 32'h0, 2);
`else
    expect_rsp("strb_part", 2, 1'b0, 32'h0, 1);
`endif
    finish_rsp();
    send(1'b0, 4'd1, 32'd9, 32'h0, 4'hF, -1);
`ifdef MEM_BRIDGE_STRB_EN
    expect_rsp("strb_rd", 2 + LAT, 1'b0, 32'h11BB33DD, 1);
`else
    expect_rsp("strb_rd", 2 + LAT, 1'b0, 32'hAABBCCDD, 1);
`endif
    finish_rsp();
`ifdef MEM_BRIDGE_STRB_EN
    send(1'b1, 4'd1, 32'd9, 32'h00000000, 4'b0000, -1);
    check("strb_zero_err", rsp_err, 1'b0);
    check("strb_zero_ce", ce_count - ce_base, 0);
    finish_rsp();
    send(1'b0, 4'd1, 32'd9, 32'h0, 4'hF, -1);
    expect_rsp("strb_zero_rd", 2 + LAT, 1'b0, 32'h11BB33DD, 1);
    finish_rsp();
`endif

    check("one_hot_ce", multi_ce, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
